aes192_key_sched: RTL

AES192_KEY_SCHED -- requirements
Module: aes192_key_sched

---
 rtl/aes_pkg.sv | 43 ++++
 rtl/aes192_key_sched_if.sv | 18 +
 rtl/aes_sbox.sv | 9 +
 rtl/aes192_key_sched.sv | 76 +++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, S-box table, Rcon, xtime and InvMixColumns helpers.
package aes_pkg;
  localparam int NR192 = 12;
  localparam int NK192 = 6;
  localparam logic [63:0] RCON = 64'h0102040810204080;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  typedef enum logic [1:0] {IDLE, EXP, DONE} ks_state_t;
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[11'd2047 - {x, 3'b000} -: 8];
  endfunction
  function automatic logic [7:0] rcon(input logic [2:0] j);
    return RCON[6'd63 - {j, 3'b000} -: 8];
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? a : 8'h0) ^ (k[1] ? x2 : 8'h0) ^ (k[2] ? x4 : 8'h0) ^ (k[3] ? x8 : 8'h0);
  endfunction
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 14) ^ gmul(a1, 11) ^ gmul(a2, 13) ^ gmul(a3, 9),
            gmul(a0, 9) ^ gmul(a1, 14) ^ gmul(a2, 11) ^ gmul(a3, 13),
            gmul(a0, 13) ^ gmul(a1, 9) ^ gmul(a2, 14) ^ gmul(a3, 11),
            gmul(a0, 11) ^ gmul(a1, 13) ^ gmul(a2, 9) ^ gmul(a3, 14)};
  endfunction
  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]), inv_mix_col(s[63:32]), inv_mix_col(s[31:0])};
  endfunction
endpackage

// File: rtl/aes192_key_sched_if.sv
// aes192_key_sched_if: key load and round-key read bus.
// o_rkey_dec exists only when AES192_KS_EQINV_EN is defined.
interface aes192_key_sched_if;
  logic [191:0] i_key;
  logic         i_key_en;
  logic [3:0]   i_rd_idx;
  logic [127:0] o_rkey;
  logic         o_key_ok;
  logic         o_busy;
`ifdef AES192_KS_EQINV_EN
  logic [127:0] o_rkey_dec;
  modport master(output i_key, i_key_en, i_rd_idx, input o_rkey, o_key_ok, o_busy, o_rkey_dec);
  modport slave(input i_key, i_key_en, i_rd_idx, output o_rkey, o_key_ok, o_busy, o_rkey_dec);
`else
  modport master(output i_key, i_key_en, i_rd_idx, input o_rkey, o_key_ok, o_busy);
  modport slave(input i_key, i_key_en, i_rd_idx, output o_rkey, o_key_ok, o_busy);
`endif
endinterface

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_a,
  output logic [7:0] o_y
);
  assign o_y = sbox(i_a);
endmodule

// File: rtl/aes192_key_sched.sv
// aes192_key_sched: AES-192 key expansion, one 6-word group per clock, 13 round keys stored.
// AES192_KS_EQINV_EN adds o_rkey_dec (InvMixColumns round keys for the equivalent inverse cipher).
module aes192_key_sched
  import aes_pkg::*;
(
  input logic r_clk,
  input logic r_rst,
  aes192_key_sched_if.slave bus
);
  localparam int NW = 4 * (NR192 + 1);
  ks_state_t    r_st, w_st_n;
  logic [3:0]   r_cnt, w_cnt_n;
  logic [31:0]  r_w [NW];
  logic [31:0]  r_g [NK192];
  logic [31:0]  w_g [NK192];
  logic [31:0]  w_rot, w_sub, w_acc;
  logic [127:0] r_rkey, w_rk;
  assign w_rot = {r_g[5][23:0], r_g[5][31:24]};
  for (genvar i = 0; i < 4; i++) begin : g_sb
    aes_sbox u_sb (.i_a(w_rot[8*i +: 8]), .o_y(w_sub[8*i +: 8]));
  end
  // Chained XOR written as a running accumulator to keep the dependency acyclic.
  always_comb begin
    w_acc = w_sub ^ {rcon(r_cnt[2:0]), 24'h0};
    for (int k = 0; k < NK192; k++) begin
      w_acc = w_acc ^ r_g[k];
      w_g[k] = w_acc;
    end
  end
  always_comb begin
    w_st_n = bus.i_key_en ? EXP : (r_st == EXP && r_cnt == 4'd7) ? DONE : r_st;
    w_cnt_n = bus.i_key_en ? 4'd0 : (r_st == EXP) ? r_cnt + 4'd1 : r_cnt;
    bus.o_busy = r_st == EXP;
    bus.o_key_ok = r_st == DONE;
  end
  always_ff @(posedge r_clk or posedge r_rst)
    if (r_rst) begin
      r_st <= IDLE;
      r_cnt <= '0;
    end else begin
      r_st <= w_st_n;
      r_cnt <= w_cnt_n;
    end
  // Group j lands at w[6j+6..6j+11]; the final group's last two words fall off the array.
  always_ff @(posedge r_clk or posedge r_rst)
    if (r_rst) begin
      r_rkey <= '0;
      for (int i = 0; i < NW; i++) r_w[i] <= '0;
      for (int i = 0; i < NK192; i++) r_g[i] <= '0;
    end else begin
      r_rkey <= w_rk;
      if (bus.i_key_en)
        for (int i = 0; i < NK192; i++) begin
          r_g[i] <= bus.i_key[191-32*i -: 32];
          r_w[i] <= bus.i_key[191-32*i -: 32];
        end
      else if (r_st == EXP) begin
        for (int i = 0; i < NK192; i++) r_g[i] <= w_g[i];
        for (int i = NK192; i < NW; i++)
          if (r_cnt == 4'((i - NK192) / NK192)) r_w[i] <= w_g[i % NK192];
      end
    end
  always_comb begin
    w_rk = '0;
    for (int k = 0; k <= NR192; k++)
      if (bus.i_rd_idx == 4'(k)) w_rk = {r_w[4*k], r_w[4*k+1], r_w[4*k+2], r_w[4*k+3]};
  end
  assign bus.o_rkey = r_rkey;
`ifdef AES192_KS_EQINV_EN
  logic [127:0] r_rkey_dec;
  always_ff @(posedge r_clk or posedge r_rst)
    if (r_rst) r_rkey_dec <= '0;
    else r_rkey_dec <= (bus.i_rd_idx == 4'd0 || bus.i_rd_idx == 4'(NR192)) ? w_rk : inv_mix_columns(w_rk);
  assign bus.o_rkey_dec = r_rkey_dec;
`endif
endmodule
